uart_tx: RTL

- UART transmitter: serialises one 8-bit byte from the APB interface block into an 11-bit frame on `txd`.
- Frame order is LSB first: 1 start bit (0), 8 data bits, 1 parity bit, 1 stop bit (1).
- Each bit is held for a fixed number of `clk` cycles (16× oversample bit period).
- Handshake: `tx_start` is set by the APB block; this block pulses `clr_tx_start` when the frame is finished so APB can clear it.

---
 rtl/uart_tx.sv | 108 ++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter. Serialises one byte into an 11-bit frame on txd, LSB first:
// start (0), 8 data bits, parity, stop (1). Each bit is held for CLKS_PER_BIT cycles.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   tx_start      request to send tx_data (level, cleared by the APB block)
//   tx_data       byte to send, sampled only when a frame starts
//   txd           serial line, idle high, driven straight from a flop
//   busy          high while a frame is in progress (SEND or CLEAR)
//   clr_tx_start  one-cycle pulse asking the APB block to clear tx_start
//   tx_done       one-cycle pulse marking frame completion (same cycle as clr_tx_start)
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       busy,
    output logic       clr_tx_start,
    output logic       tx_done
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    // Index of the stop bit; its terminal count ends the frame.
    localparam logic [3:0] LastBit = 4'd10;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StClear
    } state_e;

    state_e            state_q;
    logic [10:0]       shift_q;
    logic [3:0]        bit_cnt_q;
    logic [BaudW-1:0]  baud_cnt_q;
    logic              busy_q;
    logic              clr_q;
    logic              done_q;
    logic              parity;

    // XOR with PARITY_ODD turns even parity into odd parity.
    assign parity = (^tx_data) ^ PARITY_ODD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            shift_q    <= '1;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            busy_q     <= 1'b0;
            clr_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (tx_start) begin
                        shift_q    <= {1'b1, parity, tx_data, 1'b0};
                        bit_cnt_q  <= '0;
                        baud_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    if (baud_cnt_q == BaudLast) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LastBit) begin
                            // Stop bit done; the register already holds all ones so
                            // txd stays high through CLEAR and IDLE.
                            state_q <= StClear;
                            clr_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            shift_q <= {1'b1, shift_q[10:1]};
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                StClear: begin
                    busy_q  <= 1'b0;
                    shift_q <= '1;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    shift_q <= '1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign txd          = shift_q[0];
    assign busy         = busy_q;
    assign clr_tx_start = clr_q;
    assign tx_done      = done_q;

endmodule
